// File: rtl/video_timing_if.sv
// Raster timing bundle from video_timing_gen to its consumers.
// The generator drives the master side; scalers and DACs take the slave side.
interface video_timing_if #(
    parameter int CW = 10
);
    logic          pix_ce;
    logic          hs;
    logic          vs;
    logic          blank;
    logic [CW-1:0] DrawX;
    logic [CW-1:0] DrawY;
    logic [CW-1:0] PrefX;
    logic [CW-1:0] PrefY;
    logic          sof;
    logic          eol;

    modport master (
        output pix_ce, hs, vs, blank,
        output DrawX, DrawY, PrefX, PrefY,
        output sof, eol
    );

    modport slave (
        input pix_ce, hs, vs, blank,
        input DrawX, DrawY, PrefX, PrefY,
        input sof, eol
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel tick, lead H/V counters and a
// LOOKAHEAD-deep pipeline so fetch addresses lead the presented pixel.
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int CLK_DIV   = 2,
    parameter int LOOKAHEAD = 2,
    parameter int CW        = 10
) (
    input  logic Clk,
    input  logic Reset,
    input  logic En,
    video_timing_if.master vo
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic HP = (HS_POL != 0);
    localparam logic VP = (VS_POL != 0);

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          hs;
        logic          vs;
        logic          blank;
        logic          sof;
        logic          eol;
    } pos_t;

    function automatic pos_t rst_pos();
        pos_t p;
        p       = '0;
        p.hs    = ~HP;
        p.vs    = ~VP;
        return p;
    endfunction

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic          first_q, first_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic          pix_ce;
    pos_t          dec;
    pos_t          st_q [LOOKAHEAD];
    pos_t          st_d [LOOKAHEAD];

    assign pix_ce = En & (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q;
        if (En) begin
            div_d = pix_ce ? '0 : div_q + DW'(1);
        end
    end

    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        first_d = first_q;
        if (pix_ce) begin
            if (hc_q == CW'(H_TOTAL - 1)) begin
                hc_d = '0;
                if (vc_q == CW'(V_TOTAL - 1)) begin
                    vc_d    = '0;
                    first_d = 1'b0;
                end else begin
                    vc_d = vc_q + CW'(1);
                end
            end else begin
                hc_d = hc_q + CW'(1);
            end
        end
    end

    // sof is withheld until the lead counters have completed one full
    // frame, so the pipeline fill after reset never shows a start of frame.
    always_comb begin
        dec       = '0;
        dec.x     = hc_q;
        dec.y     = vc_q;
        dec.hs    = ((int'(hc_q) >= H_ACTIVE + H_FP) &&
                     (int'(hc_q) <  H_ACTIVE + H_FP + H_SYNC)) ? HP : ~HP;
        dec.vs    = ((int'(vc_q) >= V_ACTIVE + V_FP) &&
                     (int'(vc_q) <  V_ACTIVE + V_FP + V_SYNC)) ? VP : ~VP;
        dec.blank = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
        dec.sof   = (hc_q == '0) && (vc_q == '0) && !first_q;
        dec.eol   = (int'(hc_q) == H_ACTIVE - 1) && (int'(vc_q) < V_ACTIVE);
    end

    always_comb begin
        for (int i = 0; i < LOOKAHEAD; i++) begin
            st_d[i] = st_q[i];
        end
        if (pix_ce) begin
            st_d[0] = dec;
            for (int i = 1; i < LOOKAHEAD; i++) begin
                st_d[i] = st_q[i-1];
            end
        end
        sof_d = pix_ce & st_d[LOOKAHEAD-1].sof;
        eol_d = pix_ce & st_d[LOOKAHEAD-1].eol;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            first_q <= 1'b1;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            for (int i = 0; i < LOOKAHEAD; i++) begin
                st_q[i] <= rst_pos();
            end
        end else begin
            div_q   <= div_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            first_q <= first_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            for (int i = 0; i < LOOKAHEAD; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    assign vo.pix_ce = pix_ce;
    assign vo.PrefX  = hc_q;
    assign vo.PrefY  = vc_q;
    assign vo.DrawX  = st_q[LOOKAHEAD-1].x;
    assign vo.DrawY  = st_q[LOOKAHEAD-1].y;
    assign vo.hs     = st_q[LOOKAHEAD-1].hs;
    assign vo.vs     = st_q[LOOKAHEAD-1].vs;
    assign vo.blank  = st_q[LOOKAHEAD-1].blank;
    assign vo.sof    = sof_q & En;
    assign vo.eol    = eol_q & En;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: tick-count reference model on a small raster,
// random En/Reset stimulus, plus pinned literal expectations.
module tb_video_timing_gen;
    localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VA = 5, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FR = HT * VT;
    localparam int HP = 1, VP = 0;
    localparam int CD = 3, LA = 3, CW = 5;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic En = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;

    video_timing_if #(.CW(CW)) vo ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .CLK_DIV(CD),
        .LOOKAHEAD(LA), .CW(CW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .vo(vo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: pixel ticks since reset and clock phase inside a tick.
    int m_t = 0;
    int m_ph = 0;
    bit m_sof = 1'b0;
    bit m_eol = 1'b0;

    function automatic bit sof_at(int t);
        int p;
        if (t < LA) return 1'b0;
        p = t - LA;
        return (p % FR == 0) && (p >= FR);
    endfunction

    function automatic bit eol_at(int t);
        int p;
        if (t < LA) return 1'b0;
        p = t - LA;
        return ((p % HT) == HA - 1) && (((p / HT) % VT) < VA);
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_t   <= 0;
            m_ph  <= 0;
            m_sof <= 1'b0;
            m_eol <= 1'b0;
        end else if (En) begin
            if (m_ph == CD - 1) begin
                m_ph  <= 0;
                m_t   <= m_t + 1;
                m_sof <= sof_at(m_t + 1);
                m_eol <= eol_at(m_t + 1);
            end else begin
                m_ph  <= m_ph + 1;
                m_sof <= 1'b0;
                m_eol <= 1'b0;
            end
        end else begin
            m_sof <= 1'b0;
            m_eol <= 1'b0;
        end
    end

    int hs_min = 99, hs_max = -1, vs_min = 99, vs_max = -1;

    always @(negedge Clk) begin
        if (run) begin
            int x, y, p;
            bit hsa, vsa, bl;
            if (m_t < LA) begin
                x = 0; y = 0; hsa = 1'b0; vsa = 1'b0; bl = 1'b0;
            end else begin
                p   = m_t - LA;
                x   = p % HT;
                y   = (p / HT) % VT;
                hsa = (x >= HA + HF) && (x < HA + HF + HSW);
                vsa = (y >= VA + VF) && (y < VA + VF + VSW);
                bl  = (x < HA) && (y < VA);
            end
            chk("pix_ce", int'(vo.pix_ce), int'(En && (m_ph == CD - 1)));
            chk("PrefX", int'(vo.PrefX), m_t % HT);
            chk("PrefY", int'(vo.PrefY), (m_t / HT) % VT);
            chk("DrawX", int'(vo.DrawX), x);
            chk("DrawY", int'(vo.DrawY), y);
            chk("hs", int'(vo.hs), hsa ? HP : 1 - HP);
            chk("vs", int'(vo.vs), vsa ? VP : 1 - VP);
            chk("blank", int'(vo.blank), int'(bl));
            chk("sof", int'(vo.sof), int'(En && m_sof));
            chk("eol", int'(vo.eol), int'(En && m_eol));
            if (!Reset && vo.hs == 1'b1) begin
                if (int'(vo.DrawX) < hs_min) hs_min = int'(vo.DrawX);
                if (int'(vo.DrawX) > hs_max) hs_max = int'(vo.DrawX);
            end
            if (!Reset && vo.vs == 1'b0) begin
                if (int'(vo.DrawY) < vs_min) vs_min = int'(vo.DrawY);
                if (int'(vo.DrawY) > vs_max) vs_max = int'(vo.DrawY);
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_drawx(input int v, input bit eq, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * FR * CD; i++) begin
            @(negedge Clk);
            if ((int'(vo.DrawX) == v) == eq) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_drawx_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        int n_ce, n_clk;
        run = 1'b1;
        clk_wait(3);
        chk("rst_DrawX", int'(vo.DrawX), 0);
        chk("rst_PrefY", int'(vo.PrefY), 0);
        chk("rst_hs", int'(vo.hs), 0);
        chk("rst_vs", int'(vo.vs), 1);
        chk("rst_blank", int'(vo.blank), 0);
        Reset = 1'b0;
        clk_wait(3);
        chk("first_tick_PrefX", int'(vo.PrefX), 1);

        // First sof only after a full frame plus the pipeline fill.
        ok = 1'b0;
        for (int i = 0; i < 3 * FR * CD; i++) begin
            @(negedge Clk);
            if (vo.sof) begin
                ok = 1'b1;
                break;
            end
        end
        chk("sof_seen", int'(ok), 1);
        n_ce = 0;
        n_clk = 0;
        ok = 1'b0;
        for (int i = 0; i < 3 * FR * CD; i++) begin
            n_clk++;
            if (vo.pix_ce) n_ce++;
            @(negedge Clk);
            if (vo.sof) begin
                ok = 1'b1;
                break;
            end
        end
        chk("sof_period_seen", int'(ok), 1);
        chk("ticks_per_frame", n_ce, 135);
        chk("clks_per_frame", n_clk, 405);

        for (int i = 0; i < 1500; i++) begin
            clk_wait(1);
            En = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 399) == 0) begin
                Reset = 1'b1;
                clk_wait($urandom_range(1, 3));
                Reset = 1'b0;
            end
        end

        En = 1'b1;
        clk_wait(1);
        wait_drawx(4, 1'b0, ok);
        wait_drawx(4, 1'b1, ok);
        #2 Reset = 1'b1;
        clk_wait(3);
        chk("midline_rst_DrawX", int'(vo.DrawX), 0);
        chk("midline_rst_PrefX", int'(vo.PrefX), 0);
        Reset = 1'b0;
        clk_wait(3);
        chk("restart_PrefX", int'(vo.PrefX), 1);

        wait_drawx(5, 1'b0, ok);
        wait_drawx(5, 1'b1, ok);
        En = 1'b0;
        clk_wait(10);
        chk("hold_DrawX", int'(vo.DrawX), 5);
        En = 1'b1;
        clk_wait(3);
        chk("resume_DrawX", int'(vo.DrawX), 6);

        for (int i = 0; i < 600; i++) begin
            clk_wait(1);
            En = ($urandom_range(0, 7) != 0);
        end
        En = 1'b1;
        clk_wait(2 * FR * CD);
        @(negedge Clk);
        run = 1'b0;
        chk("hs_x_min", hs_min, 10);
        chk("hs_x_max", hs_max, 12);
        chk("vs_y_min", vs_min, 6);
        chk("vs_y_max", vs_max, 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
